// File: rtl/encoder_gate_ctrl_pkg.sv
//----------------------------------------------------------------------
// encoder_pkg: shared state encoding and default widths. Rev 1.0
//----------------------------------------------------------------------
`default_nettype none

package encoder_pkg;

  localparam int unsigned C_CW_DEFAULT     = 8;
  localparam int unsigned C_GW_DEFAULT     = 24;
  localparam int unsigned C_SETTLE_DEFAULT = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLR    = 3'd1,
    ST_GATE   = 3'd2,
    ST_SETTLE = 3'd3,
    ST_OUT    = 3'd4
  } state_t;

endpackage

`default_nettype wire

// File: rtl/encoder_gate_ctrl_if.sv
//----------------------------------------------------------------------
// encoder_gate_ctrl_if: control, encoder and sample-handshake bundle. Rev 1.0
//----------------------------------------------------------------------
`default_nettype none

interface encoder_gate_ctrl_if #(
  parameter int CW = 8,
  parameter int GW = 24
) ();

  logic          i_start;
  logic          i_cont;
  logic [GW-1:0] i_gate_len;
  logic [CW-1:0] i_enc_count;
  logic          i_sample_ready;
  logic          o_enc_en;
  logic          o_enc_clr;
  logic          o_busy;
  logic [CW-1:0] o_sample;
  logic          o_sample_ovf;
  logic          o_sample_valid;

  modport slave (
    input  i_start, i_cont, i_gate_len, i_enc_count, i_sample_ready,
    output o_enc_en, o_enc_clr, o_busy, o_sample, o_sample_ovf, o_sample_valid
  );

  modport master (
    output i_start, i_cont, i_gate_len, i_enc_count, i_sample_ready,
    input  o_enc_en, o_enc_clr, o_busy, o_sample, o_sample_ovf, o_sample_valid
  );

endinterface

`default_nettype wire

// File: rtl/encoder_gate_timer.sv
//----------------------------------------------------------------------
// encoder_gate_timer: loadable down-counter shared by GATE and SETTLE. Rev 1.0
//----------------------------------------------------------------------
`default_nettype none

module encoder_gate_timer #(
  parameter int GW = 24
) (
  input  wire logic          clk,
  input  wire logic          rst,
  input  wire logic          i_load,
  input  wire logic [GW-1:0] i_load_val,
  input  wire logic          i_dec,
  output logic               o_zero
);

  logic [GW-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && !o_zero) begin
      r_count <= r_count - {{(GW-1){1'b0}}, 1'b1};
    end
  end

  assign o_zero = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/encoder_gate_ctrl.sv
//----------------------------------------------------------------------
// encoder_gate_ctrl: clear / gate / settle / capture sequencer. Rev 1.0
//----------------------------------------------------------------------
`default_nettype none

module encoder_gate_ctrl
  import encoder_pkg::*;
#(
  parameter int CW     = C_CW_DEFAULT,
  parameter int GW     = C_GW_DEFAULT,
  parameter int SETTLE = C_SETTLE_DEFAULT
) (
  input  wire logic         clk,
  input  wire logic         rst,
  encoder_gate_ctrl_if.slave ctrl_if
);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [GW-1:0] r_gl;
  logic          w_tmr_load;
  logic [GW-1:0] w_tmr_val;
  logic          w_tmr_dec;
  logic          w_tmr_zero;
  logic [CW-1:0] r_prev;
  logic          r_ovf;
  logic          w_wrap;
  logic          w_capture;
  logic          w_latch_gl;
  logic [CW-1:0] r_sample;
  logic          r_sample_ovf;
  logic          r_enc_en;
  logic          r_enc_clr;
  logic          r_busy;
  logic          r_valid;

  encoder_gate_timer #(.GW(GW)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .i_dec      (w_tmr_dec),
    .o_zero     (w_tmr_zero)
  );

  // Timer is loaded with length-1 so the zero flag marks the last cycle of a phase.
  always_comb begin
    w_state_nxt = r_state;
    w_tmr_load  = 1'b0;
    w_tmr_val   = '0;
    w_tmr_dec   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (ctrl_if.i_start || ctrl_if.i_cont) w_state_nxt = ST_CLR;
      end
      ST_CLR: begin
        w_state_nxt = ST_GATE;
        w_tmr_load  = 1'b1;
        w_tmr_val   = r_gl - {{(GW-1){1'b0}}, 1'b1};
      end
      ST_GATE: begin
        if (w_tmr_zero) begin
          w_state_nxt = ST_SETTLE;
          w_tmr_load  = 1'b1;
          w_tmr_val   = GW'(SETTLE - 1);
        end else begin
          w_tmr_dec = 1'b1;
        end
      end
      ST_SETTLE: begin
        if (w_tmr_zero) w_state_nxt = ST_OUT;
        else            w_tmr_dec   = 1'b1;
      end
      ST_OUT: begin
        if (ctrl_if.i_sample_ready) w_state_nxt = ctrl_if.i_cont ? ST_CLR : ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_wrap     = (ctrl_if.i_enc_count < r_prev);
  assign w_capture  = (r_state == ST_SETTLE) && w_tmr_zero;
  assign w_latch_gl = (w_state_nxt == ST_CLR);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_gl         <= '0;
      r_prev       <= '0;
      r_ovf        <= 1'b0;
      r_sample     <= '0;
      r_sample_ovf <= 1'b0;
      r_enc_en     <= 1'b0;
      r_enc_clr    <= 1'b0;
      r_busy       <= 1'b0;
      r_valid      <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_latch_gl) begin
        r_gl <= (ctrl_if.i_gate_len == '0) ? {{(GW-1){1'b0}}, 1'b1} : ctrl_if.i_gate_len;
      end
      if (r_state == ST_CLR) begin
        r_prev <= '0;
        r_ovf  <= 1'b0;
      end else begin
        r_prev <= ctrl_if.i_enc_count;
        if ((r_state == ST_GATE || r_state == ST_SETTLE) && w_wrap) r_ovf <= 1'b1;
      end
      // A wrap seen on the capture cycle itself still belongs to this sample.
      if (w_capture) begin
        r_sample     <= ctrl_if.i_enc_count;
        r_sample_ovf <= r_ovf | w_wrap;
      end
      r_enc_clr <= (w_state_nxt == ST_CLR);
      r_enc_en  <= (w_state_nxt == ST_GATE);
      r_busy    <= (w_state_nxt != ST_IDLE);
      r_valid   <= (w_state_nxt == ST_OUT);
    end
  end

  assign ctrl_if.o_enc_en       = r_enc_en;
  assign ctrl_if.o_enc_clr      = r_enc_clr;
  assign ctrl_if.o_busy         = r_busy;
  assign ctrl_if.o_sample       = r_sample;
  assign ctrl_if.o_sample_ovf   = r_sample_ovf;
  assign ctrl_if.o_sample_valid = r_valid;

endmodule

`default_nettype wire
